// File: rtl/sipo_framer.sv
// sipo_framer: serial-in/parallel-out deserialiser with bit strobe, alignment clear and valid/ready output
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   serial_in     serial data bit, sampled when serial_valid is high
//   serial_valid  bit strobe, one bit consumed per strobed edge
//   align_clr     drop the partial word and restart at bit 0 (bit not consumed)
//   parallel_out  assembled word, held until accepted
//   out_valid     parallel_out holds an unaccepted word
//   out_ready     consumer accepts when out_valid && out_ready at an edge
//   bit_cnt       bits collected in the current partial word
//   overrun       one-cycle pulse when a completed word is dropped
module sipo_framer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             align_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_po;
    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic             r_ovr;
    logic [WIDTH-1:0] w_shift;
    logic             w_take;
    logic             w_done;
    logic             w_full;

    // The completed word includes the bit sampled on the completing edge.
    assign w_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], serial_in} : {serial_in, r_sr[WIDTH-1:1]};
    assign w_take  = serial_valid && !align_clr;
    assign w_done  = w_take && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_full  = (r_state == FULL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_po    <= '0;
            r_state <= EMPTY;
            r_ovr   <= 1'b0;
        end else begin
            if (align_clr) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else if (serial_valid) begin
                r_sr  <= w_shift;
                r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
            end
            // A word finishing while the previous one is still unaccepted is lost.
            r_ovr <= w_done && w_full && !out_ready;
            if (w_done && (!w_full || out_ready)) begin
                r_po    <= w_shift;
                r_state <= FULL;
            end else if (!w_done && w_full && out_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign parallel_out = r_po;
    assign out_valid    = w_full;
    assign bit_cnt      = r_cnt;
    assign overrun      = r_ovr;
endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: self-checking bench for sipo_framer, both bit orders, against a bit-list model
module tb_sipo_framer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         si = 1'b0;
    logic         sv = 1'b0;
    logic         ac = 1'b0;
    logic         rdy = 1'b0;
    logic [W-1:0] po_m, po_l;
    logic         ov_m, ov_l, of_m, of_l;
    logic [2:0]   cnt_m, cnt_l;

    int total = 0;
    int bad   = 0;

    int           m_bits[W];
    int           m_n = 0;
    logic [W-1:0] m_po_m = '0, m_po_l = '0;
    logic         m_valid = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .serial_in(si), .serial_valid(sv), .align_clr(ac),
        .parallel_out(po_m), .out_valid(ov_m), .out_ready(rdy), .bit_cnt(cnt_m), .overrun(of_m)
    );

    sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .serial_in(si), .serial_valid(sv), .align_clr(ac),
        .parallel_out(po_l), .out_valid(ov_l), .out_ready(rdy), .bit_cnt(cnt_l), .overrun(of_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: keep the received bits as a list, build words by arithmetic when W bits are in.
    task automatic model(input logic r, input logic b, input logic v, input logic c, input logic a);
        logic done;
        int wm, wl;
        if (!r) begin
            m_n = 0; m_po_m = '0; m_po_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        done = 1'b0;
        if (c) m_n = 0;
        else if (v) begin
            m_bits[m_n] = int'(b);
            m_n++;
            if (m_n == W) begin
                done = 1'b1;
                m_n  = 0;
            end
        end
        wm = 0; wl = 0;
        for (int i = 0; i < W; i++) begin
            wm = wm * 2 + m_bits[i];
            wl = wl + (m_bits[i] << i);
        end
        m_ovr = done && m_valid && !a;
        if (done && (!m_valid || a)) begin
            m_po_m = W'(wm); m_po_l = W'(wl); m_valid = 1'b1;
        end else if (!done && m_valid && a) m_valid = 1'b0;
    endtask

    task automatic step(input logic r, input logic b, input logic v, input logic c, input logic a);
        rst = r; si = b; sv = v; ac = c; rdy = a;
        model(r, b, v, c, a);
        @(posedge clk);
        #1;
        chk("po_msb", po_m, m_po_m);
        chk("po_lsb", po_l, m_po_l);
        chk("valid_msb", ov_m, m_valid);
        chk("valid_lsb", ov_l, m_valid);
        chk("cnt_msb", cnt_m, m_n);
        chk("cnt_lsb", cnt_l, m_n);
        chk("ovr_msb", of_m, m_ovr);
        chk("ovr_lsb", of_l, m_ovr);
    endtask

    task automatic send(input logic [W-1:0] w, input logic a, input bit gaps);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, w[i], 1'b1, 1'b0, a);
            if (gaps) step(1'b1, 1'($urandom), 1'b0, 1'b0, a);
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_bits[i] = 0;
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_po", po_m, 0);
        chk("reset_valid", ov_m, 0);
        chk("reset_cnt", cnt_m, 0);

        send(8'hE8, 1'b1, 1'b0);
        chk("t1_msb_word", po_m, 8'hE8);
        chk("t2_lsb_word", po_l, 8'h17);
        chk("t1_valid", ov_m, 1);
        chk("t1_cnt", cnt_m, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", ov_m, 0);
        chk("t1_po_hold", po_m, 8'hE8);

        send(8'hE8, 1'b1, 1'b1);
        chk("t3_gapped_word", po_m, 8'hE8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        send(8'hE8, 1'b0, 1'b0);
        chk("t4_first_word", po_m, 8'hE8);
        send(8'hA5, 1'b0, 1'b0);
        chk("t4_overrun", of_m, 1);
        chk("t4_po_kept", po_m, 8'hE8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_overrun_pulse", of_m, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_accept", ov_m, 0);

        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_clr_cnt", cnt_m, 0);
        send(8'h3C, 1'b1, 1'b0);
        chk("t5_aligned", po_m, 8'h3C);
        chk("t5_aligned_lsb", po_l, 8'h3C);

        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_valid", ov_m, 0);
        chk("t6_rst_po", po_m, 0);
        chk("t6_rst_cnt", cnt_m, 0);
        send(8'h5A, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_held", ov_m, 0);
        send(8'h96, 1'b1, 1'b0);
        chk("t6_clean", po_m, 8'h96);
        send(8'hC3, 1'b1, 1'b0);
        chk("t6_b2b_word", po_m, 8'hC3);
        chk("t6_b2b_valid", ov_m, 1);
        chk("t6_b2b_noovr", of_m, 0);

        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
